game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60: frame_clk ticks per second.
REQ-002 SHALL have parameter COUNT_SECS, default 3: pre-play countdown length in seconds.
REQ-003 SHALL have parameter RESULT_HOLD, default 120: minimum frames the result screen is shown before input is accepted.
REQ-004 SHALL have port frame_clk, input, 1: the single clock, one tick per video frame.
REQ-005 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port keycode, input, 8: current USB keyboard keycode; 8'h00 means no key.
REQ-007 SHALL have port song_len, input, 16: song length in frames, sampled on entry to PLAY.
REQ-008 SHALL have port startscreen, output, 1: high while the start-screen text is displayed.
REQ-009 SHALL have port countdown_digit, output, 2: seconds remaining (3..1) during COUNTDOWN, otherwise 0.
REQ-010 SHALL have port playing, output, 1: high in PLAY only.
REQ-011 SHALL have port paused, output, 1: high in PAUSE only.
REQ-012 SHALL have port result_screen, output, 1: high in RESULT only.
REQ-013 SHALL have port song_frame, output, 16: elapsed song frames.
REQ-014 SHALL have port score_clear, output, 1: one-frame pulse that clears the score bars.

Function
REQ-015 SHALL define press(K) as keycode==K this frame and registered previous keycode!=K; a held key SHALL produce exactly one press.
REQ-016 SHALL use SPACE=8'h2C and ESC=8'h29; all other keycodes SHALL be ignored.
REQ-017 SHALL implement the states START, COUNTDOWN, PLAY, PAUSE and RESULT, with every output registered.
REQ-018 START: startscreen=1; press(SPACE) SHALL go to COUNTDOWN, load the countdown counter with COUNT_SECS*FRAMES_PER_SEC-1, and pulse score_clear for the next frame.
REQ-019 COUNTDOWN: countdown_digit SHALL be counter/FRAMES_PER_SEC+1 (3,2,1 for the defaults); press(ESC) SHALL abort to START.
REQ-020 COUNTDOWN: when the counter reaches 0, the next frame SHALL enter PLAY with song_frame=0 and song_len latched.
REQ-021 PLAY: song_frame SHALL increment by 1 per frame; when song_frame==latched_len-1, the next state SHALL be RESULT.
REQ-022 PLAY: press(ESC) SHALL go to PAUSE; song_frame SHALL hold in PAUSE.
REQ-023 PAUSE: press(ESC) or press(SPACE) SHALL resume to PLAY with song_frame unchanged.
REQ-024 If song end and press(ESC) coincide in PLAY, RESULT SHALL win.
REQ-025 If latched song_len==0, PLAY SHALL last exactly one frame and then enter RESULT.
REQ-026 song_frame SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-027 RESULT: song_frame SHALL hold its final value; press(SPACE) SHALL be ignored until RESULT_HOLD frames have elapsed, and afterwards SHALL go to START.
REQ-028 score_clear SHALL also pulse for one frame on the transition from RESULT to START.
REQ-029 Counter widths SHALL be $clog2 of their maximum values; arithmetic SHALL be unsigned.

Reset
REQ-030 Reset_n low SHALL asynchronously force: state START, startscreen=1, all other outputs 0, counters 0, and previous keycode 8'h00.
REQ-031 Reset asserted mid-PLAY or mid-PAUSE SHALL discard song progress, and no score_clear pulse SHALL be generated.
REQ-032 After reset release, a key already held SHALL count as a press on the first frame.

Structure
REQ-033 A shared package game_pkg SHALL hold the state enum game_state_t, KEY_SPACE, KEY_ESC and the default timing constants.
REQ-034 One sub-module key_edge (a keycode register plus press detection for a parameterised key) SHALL be instantiated once per key.
REQ-035 The start-screen display module SHALL consume startscreen and SHALL no longer contain its own state machine.

Verification
REQ-036 Reset, then SPACE held for 5 frames -> exactly one score_clear pulse, startscreen=0, countdown_digit=3.
REQ-037 Full countdown at defaults -> digit 3 for 60 frames, 2 for 60 frames, 1 for 60 frames, then playing=1 with song_frame=0.
REQ-038 song_len=100, ESC at song_frame=40, 30 frames idle, then ESC -> song_frame holds 40 while paused, and RESULT is entered after 100 PLAY frames total.
REQ-039 song_len=50, ESC pressed on the last PLAY frame -> result_screen=1 and paused stays 0.
REQ-040 In RESULT, SPACE at hold frame 10 -> ignored; SPACE at frame 120 -> START with one score_clear pulse.
REQ-041 Reset_n pulled low mid-PAUSE, off-clock-edge -> outputs return immediately to reset values; song_len=0 run -> exactly one playing frame.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared game-flow state encoding, key codes and timing defaults
// Rev 1.0
// ============================================================================
package game_pkg;

   typedef enum logic [2:0] {
      ST_START     = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_RESULT    = 3'd4
   } game_state_t;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_ESC   = 8'h29;

   localparam int DEF_FRAMES_PER_SEC = 60;
   localparam int DEF_COUNT_SECS     = 3;
   localparam int DEF_RESULT_HOLD    = 120;

endpackage
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// key_edge : keycode register plus press detection for one key
// Rev 1.0
// ============================================================================
module key_edge #(
   parameter logic [7:0] KEY = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_keycode,
   output logic       o_press
);

   logic [7:0] r_prev;

   // Reset clears the history so a key held through reset release still reports a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 8'h00;
      end else begin
         r_prev <= i_keycode;
      end
   end

   assign o_press = (i_keycode == KEY) && (r_prev != KEY);

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// game_flow_ctrl : start / countdown / play / pause / result sequencing
// Rev 1.0
// ============================================================================
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
   parameter int COUNT_SECS     = DEF_COUNT_SECS,
   parameter int RESULT_HOLD    = DEF_RESULT_HOLD
) (
   input  logic        frame_clk,
   input  logic        Reset_n,
   input  logic [7:0]  keycode,
   input  logic [15:0] song_len,
   output logic        startscreen,
   output logic [1:0]  countdown_digit,
   output logic        playing,
   output logic        paused,
   output logic        result_screen,
   output logic [15:0] song_frame,
   output logic        score_clear
);

   localparam int CD_TOTAL = COUNT_SECS * FRAMES_PER_SEC;
   localparam int CD_W     = (CD_TOTAL > 1) ? $clog2(CD_TOTAL) : 1;
   localparam int HOLD_W   = $clog2(RESULT_HOLD + 1);

   localparam logic [CD_W-1:0]   c_CD_LOAD    = CD_W'(CD_TOTAL - 1);
   localparam logic [1:0]        c_DIGIT_LOAD = 2'(((CD_TOTAL - 1) / FRAMES_PER_SEC) + 1);
   localparam logic [HOLD_W-1:0] c_HOLD_MAX   = HOLD_W'(RESULT_HOLD);

   game_state_t       r_state;
   logic [CD_W-1:0]   r_cd;
   logic [HOLD_W-1:0] r_hold;
   logic [15:0]       r_len;
   logic              r_startscreen;
   logic [1:0]        r_digit;
   logic              r_playing;
   logic              r_paused;
   logic              r_result;
   logic [15:0]       r_song_frame;
   logic              r_score_clear;

   logic              w_press_space;
   logic              w_press_esc;
   logic [CD_W-1:0]   w_cd_dec;
   logic [1:0]        w_digit_next;
   logic              w_song_end;

   key_edge #(.KEY(KEY_SPACE)) u_key_space (
      .clk       (frame_clk),
      .rst_n     (Reset_n),
      .i_keycode (keycode),
      .o_press   (w_press_space)
   );

   key_edge #(.KEY(KEY_ESC)) u_key_esc (
      .clk       (frame_clk),
      .rst_n     (Reset_n),
      .i_keycode (keycode),
      .o_press   (w_press_esc)
   );

   assign w_cd_dec     = r_cd - CD_W'(1);
   assign w_digit_next = 2'((int'(w_cd_dec) / FRAMES_PER_SEC) + 1);
   // A zero-length song still plays one frame; otherwise end on the last frame index.
   assign w_song_end   = (r_len == 16'd0) || (r_song_frame == (r_len - 16'd1));

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= ST_START;
         r_cd          <= '0;
         r_hold        <= '0;
         r_len         <= 16'd0;
         r_startscreen <= 1'b1;
         r_digit       <= 2'd0;
         r_playing     <= 1'b0;
         r_paused      <= 1'b0;
         r_result      <= 1'b0;
         r_song_frame  <= 16'd0;
         r_score_clear <= 1'b0;
      end else begin
         r_score_clear <= 1'b0;
         case (r_state)
            ST_START: begin
               if (w_press_space) begin
                  r_state       <= ST_COUNTDOWN;
                  r_cd          <= c_CD_LOAD;
                  r_digit       <= c_DIGIT_LOAD;
                  r_startscreen <= 1'b0;
                  r_score_clear <= 1'b1;
               end
            end
            ST_COUNTDOWN: begin
               if (w_press_esc) begin
                  r_state       <= ST_START;
                  r_cd          <= '0;
                  r_digit       <= 2'd0;
                  r_startscreen <= 1'b1;
               end else if (r_cd == '0) begin
                  r_state      <= ST_PLAY;
                  r_digit      <= 2'd0;
                  r_playing    <= 1'b1;
                  r_song_frame <= 16'd0;
                  r_len        <= song_len;
               end else begin
                  r_cd    <= w_cd_dec;
                  r_digit <= w_digit_next;
               end
            end
            ST_PLAY: begin
               // Song end takes priority over a simultaneous pause request.
               if (w_song_end) begin
                  r_state   <= ST_RESULT;
                  r_playing <= 1'b0;
                  r_result  <= 1'b1;
                  r_hold    <= '0;
               end else if (w_press_esc) begin
                  r_state   <= ST_PAUSE;
                  r_playing <= 1'b0;
                  r_paused  <= 1'b1;
               end else if (r_song_frame != 16'hFFFF) begin
                  r_song_frame <= r_song_frame + 16'd1;
               end
            end
            ST_PAUSE: begin
               if (w_press_esc || w_press_space) begin
                  r_state   <= ST_PLAY;
                  r_paused  <= 1'b0;
                  r_playing <= 1'b1;
               end
            end
            ST_RESULT: begin
               if (w_press_space && (r_hold == c_HOLD_MAX)) begin
                  r_state       <= ST_START;
                  r_result      <= 1'b0;
                  r_startscreen <= 1'b1;
                  r_score_clear <= 1'b1;
                  r_song_frame  <= 16'd0;
                  r_hold        <= '0;
               end else if (r_hold != c_HOLD_MAX) begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            default: begin
               r_state       <= ST_START;
               r_cd          <= '0;
               r_hold        <= '0;
               r_startscreen <= 1'b1;
               r_digit       <= 2'd0;
               r_playing     <= 1'b0;
               r_paused      <= 1'b0;
               r_result      <= 1'b0;
               r_song_frame  <= 16'd0;
            end
         endcase
      end
   end

   assign startscreen     = r_startscreen;
   assign countdown_digit = r_digit;
   assign playing         = r_playing;
   assign paused          = r_paused;
   assign result_screen   = r_result;
   assign song_frame      = r_song_frame;
   assign score_clear     = r_score_clear;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_flow_ctrl : directed table-driven bench for game_flow_ctrl
// Rev 1.0
// ============================================================================
module tb_game_flow_ctrl;

   localparam logic [7:0] K_SPACE = 8'h2C;
   localparam logic [7:0] K_ESC   = 8'h29;
   localparam logic [7:0] K_NONE  = 8'h00;
   localparam logic [22:0] c_RST_OBS = {1'b1, 2'd0, 4'b0000, 16'h0000};

   logic        frame_clk;
   logic        Reset_n;
   logic [7:0]  keycode;
   logic [15:0] song_len;
   logic        startscreen;
   logic [1:0]  countdown_digit;
   logic        playing;
   logic        paused;
   logic        result_screen;
   logic [15:0] song_frame;
   logic        score_clear;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [7:0] key;
      logic       ss;
      logic [1:0] dig;
      logic       pl;
      logic       pa;
      logic       rs;
      logic       sc;
   } vec_t;

   vec_t tbl [10];

   game_flow_ctrl u_dut (
      .frame_clk       (frame_clk),
      .Reset_n         (Reset_n),
      .keycode         (keycode),
      .song_len        (song_len),
      .startscreen     (startscreen),
      .countdown_digit (countdown_digit),
      .playing         (playing),
      .paused          (paused),
      .result_screen   (result_screen),
      .song_frame      (song_frame),
      .score_clear     (score_clear)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply a key for one frame and settle just after the clock edge.
   task automatic frame(input logic [7:0] k);
      keycode = k;
      @(posedge frame_clk);
      #1;
   endtask

   function automatic logic [22:0] obs_all();
      return {startscreen, countdown_digit, playing, paused, result_screen, score_clear, song_frame};
   endfunction

   function automatic logic [6:0] obs_ctl();
      return {startscreen, countdown_digit, playing, paused, result_screen, score_clear};
   endfunction

   task automatic countdown_to_play();
      frame(K_SPACE);
      chk("start_clear", 32'(score_clear), 32'd1);
      for (int i = 0; i < 180; i++) frame(K_NONE);
      chk("play_entry", 32'({playing, song_frame}), 32'({1'b1, 16'd0}));
   endtask

   initial begin
      int n;
      n_cmp    = 0;
      n_fail   = 0;
      Reset_n  = 1'b0;
      keycode  = K_NONE;
      song_len = 16'd100;

      tbl[0] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{K_NONE,  1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{K_ESC,   1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{K_ESC,   1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{K_NONE,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{K_SPACE, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};

      #12;
      chk("reset_state", 32'(obs_all()), 32'(c_RST_OBS));
      @(negedge frame_clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         frame(tbl[i].key);
         chk($sformatf("vec%0d", i), 32'(obs_ctl()),
             32'({tbl[i].ss, tbl[i].dig, tbl[i].pl, tbl[i].pa, tbl[i].rs, tbl[i].sc}));
      end

      // Full countdown: 60 frames each of 3, 2, 1.
      for (int i = 0; i < 180; i++) begin
         chk($sformatf("cd_digit%0d", i), 32'({playing, countdown_digit}),
             32'({1'b0, (i < 60) ? 2'd3 : (i < 120) ? 2'd2 : 2'd1}));
         frame(K_NONE);
      end
      chk("cd_to_play", 32'({playing, countdown_digit, song_frame}), 32'({1'b1, 2'd0, 16'd0}));

      // Pause at frame 40, idle 30 frames, resume, run to the end of a 100-frame song.
      for (int b = 0; b < 100 && song_frame != 16'd40; b++) frame(K_NONE);
      chk("reach40", 32'({playing, song_frame}), 32'({1'b1, 16'd40}));
      frame(K_ESC);
      chk("pause_enter", 32'({playing, paused, song_frame}), 32'({1'b0, 1'b1, 16'd40}));
      for (int i = 0; i < 30; i++) begin
         frame(K_NONE);
         chk($sformatf("pause_hold%0d", i), 32'({paused, song_frame}), 32'({1'b1, 16'd40}));
      end
      frame(K_ESC);
      chk("resume", 32'({playing, paused, song_frame}), 32'({1'b1, 1'b0, 16'd40}));
      n = 0;
      while (!result_screen && n < 200) begin
         frame(K_NONE);
         n++;
      end
      chk("resume_to_result_frames", 32'(n), 32'd60);
      chk("result_entry", 32'({result_screen, playing, song_frame}), 32'({1'b1, 1'b0, 16'd99}));

      // Result hold: SPACE at hold frames 10 and 119 ignored, accepted at 120.
      for (int i = 0; i < 10; i++) frame(K_NONE);
      frame(K_SPACE);
      chk("hold10_ignored", 32'({result_screen, startscreen, score_clear}), 32'({1'b1, 1'b0, 1'b0}));
      for (int i = 0; i < 108; i++) frame(K_NONE);
      frame(K_SPACE);
      chk("hold119_ignored", 32'({result_screen, startscreen, song_frame}), 32'({1'b1, 1'b0, 16'd99}));
      frame(K_NONE);
      chk("hold_sat", 32'(result_screen), 32'd1);
      frame(K_SPACE);
      chk("result_to_start", 32'({startscreen, result_screen, score_clear, song_frame}),
          32'({1'b1, 1'b0, 1'b1, 16'd0}));
      frame(K_NONE);
      chk("start_clear_once", 32'({startscreen, score_clear}), 32'({1'b1, 1'b0}));

      // Song end coinciding with ESC; song length latched on PLAY entry.
      song_len = 16'd50;
      countdown_to_play();
      song_len = 16'd7;
      for (int b = 0; b < 100 && song_frame != 16'd49; b++) frame(K_NONE);
      chk("reach49", 32'({playing, song_frame}), 32'({1'b1, 16'd49}));
      frame(K_ESC);
      chk("end_beats_esc", 32'({result_screen, paused, playing, song_frame}),
          32'({1'b1, 1'b0, 1'b0, 16'd49}));

      // Asynchronous reset between edges, then a zero-length song.
      keycode = K_NONE;
      #3 Reset_n = 1'b0;
      #1 chk("async_reset_result", 32'(obs_all()), 32'(c_RST_OBS));
      song_len = 16'd0;
      @(posedge frame_clk);
      #1 chk("reset_held", 32'(obs_all()), 32'(c_RST_OBS));
      #2 Reset_n = 1'b1;
      countdown_to_play();
      frame(K_NONE);
      chk("len0_one_frame", 32'({result_screen, playing, song_frame}), 32'({1'b1, 1'b0, 16'd0}));

      // Reset mid-PAUSE with SPACE held through release.
      #2 Reset_n = 1'b0;
      #2 Reset_n = 1'b1;
      song_len = 16'd100;
      countdown_to_play();
      for (int i = 0; i < 5; i++) frame(K_NONE);
      frame(K_ESC);
      chk("pause_at5", 32'({paused, song_frame}), 32'({1'b1, 16'd5}));
      frame(K_NONE);
      keycode = K_SPACE;
      #3 Reset_n = 1'b0;
      #1 chk("async_reset_pause", 32'(obs_all()), 32'(c_RST_OBS));
      @(posedge frame_clk);
      #1 chk("reset_no_clear", 32'(obs_all()), 32'(c_RST_OBS));
      #2 Reset_n = 1'b1;
      frame(K_SPACE);
      chk("held_key_press", 32'({startscreen, countdown_digit, score_clear}), 32'({1'b0, 2'd3, 1'b1}));
      frame(K_SPACE);
      chk("held_key_once", 32'({startscreen, score_clear}), 32'({1'b0, 1'b0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
